// File: rtl/buffer_access_arbiter.sv
//==============================================================================
// Module      : buffer_access_arbiter
// Description : Round-robin read/write arbiter and in-flight read tracker
//               placed in front of a single feature buffer. Three readers
//               (agg, mm, save), two writers (agg, load). Optional
//               same-cycle read-after-write blocking when the macro
//               BUFFER_ARB_RAW_CHECK_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module buffer_access_arbiter #(
  parameter int BUFFER_ADDR_WIDTH = 11,
  parameter int BUFFER_DATA_WIDTH = 512,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         agg_rd_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] agg_rd_addr,
  output logic                         agg_rd_ready,
  input  logic                         mm_rd_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] mm_rd_addr,
  output logic                         mm_rd_ready,
  input  logic                         save_rd_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] save_rd_addr,
  output logic                         save_rd_ready,
  input  logic                         agg_wr_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] agg_wr_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] agg_wr_data,
  output logic                         agg_wr_ready,
  input  logic                         load_wr_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] load_wr_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] load_wr_data,
  output logic                         load_wr_ready,
  output logic                         buf_agg_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_agg_read_addr,
  output logic                         buf_mm_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_mm_read_addr,
  output logic                         buf_save_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_save_read_addr,
  output logic                         buf_agg_write_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_agg_write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] buf_agg_write_data,
  output logic                         buf_load_write_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_load_write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] buf_load_write_data,
  input  logic                         buf_agg_read_data_valid,
  input  logic                         buf_mm_read_data_valid,
  input  logic                         buf_save_read_data_valid,
  output logic                         track_err
);

  localparam int            CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);
  // Reader indices: 0 = agg, 1 = mm, 2 = save. Reset pointer = save so agg is searched first.
  localparam logic [1:0]    C_RD_PTR_RST = 2'd2;

  logic [BUFFER_ADDR_WIDTH-1:0] w_rd_addr [3];
  logic [2:0]                   w_rd_valid;
  logic [2:0]                   w_ret;
  logic [2:0]                   w_raw_block;
  logic [2:0]                   w_zero;
  logic [3:0]                   w_elig;
  logic [2:0]                   w_rd_gnt;
  logic                         w_rd_any;
  logic [1:0]                   w_rd_idx;
  logic [1:0]                   w_cand;
  logic [1:0]                   w_wr_gnt;   // bit0 = agg, bit1 = load
  logic                         w_wr_any;
  logic [BUFFER_ADDR_WIDTH-1:0] w_wr_addr;
  logic [2:0]                   w_underflow;

  logic [CW-1:0] r_cnt [3];
  logic [1:0]    r_rd_ptr;
  logic          r_wr_ptr;   // last granted writer: 0 = agg, 1 = load
  logic          r_track_err;

  assign w_rd_addr[0] = agg_rd_addr;
  assign w_rd_addr[1] = mm_rd_addr;
  assign w_rd_addr[2] = save_rd_addr;
  assign w_rd_valid   = {save_rd_valid, mm_rd_valid, agg_rd_valid};
  assign w_ret        = {buf_save_read_data_valid, buf_mm_read_data_valid, buf_agg_read_data_valid};

  // Write arbitration: alternate between agg and load when both request.
  always_comb begin
    w_wr_gnt = 2'b00;
    if (agg_wr_valid && load_wr_valid) w_wr_gnt = r_wr_ptr ? 2'b01 : 2'b10;
    else if (agg_wr_valid)             w_wr_gnt = 2'b01;
    else if (load_wr_valid)            w_wr_gnt = 2'b10;
  end

  assign w_wr_any      = |w_wr_gnt;
  assign w_wr_addr     = w_wr_gnt[1] ? load_wr_addr : agg_wr_addr;
  assign agg_wr_ready  = w_wr_gnt[0];
  assign load_wr_ready = w_wr_gnt[1];

`ifdef BUFFER_ARB_RAW_CHECK_EN
  // A read to the address being written this cycle waits; the write wins.
  for (genvar i = 0; i < 3; i++) begin : g_raw
    assign w_raw_block[i] = w_wr_any && (w_rd_addr[i] == w_wr_addr);
  end
`else
  assign w_raw_block = 3'b000;
`endif

  // Eligibility uses the current count only; a same-cycle return frees a slot next cycle.
  for (genvar i = 0; i < 3; i++) begin : g_elig
    assign w_zero[i] = (r_cnt[i] == '0);
    assign w_elig[i] = w_rd_valid[i] && (r_cnt[i] < C_MAX) && !w_raw_block[i];
  end
  assign w_elig[3] = 1'b0;

  // Read arbitration: search starts just after the last granted reader.
  always_comb begin
    w_rd_any = 1'b0;
    w_rd_idx = r_rd_ptr;
    w_cand   = r_rd_ptr;
    for (int k = 0; k < 3; k++) begin
      w_cand = (w_cand == 2'd2) ? 2'd0 : w_cand + 2'd1;
      if (!w_rd_any && w_elig[w_cand]) begin
        w_rd_any = 1'b1;
        w_rd_idx = w_cand;
      end
    end
  end

  assign w_rd_gnt      = w_rd_any ? (3'b001 << w_rd_idx) : 3'b000;
  assign agg_rd_ready  = w_rd_gnt[0];
  assign mm_rd_ready   = w_rd_gnt[1];
  assign save_rd_ready = w_rd_gnt[2];

  // A return with no concurrent grant against an empty counter is an underflow.
  assign w_underflow = w_ret & ~w_rd_gnt & w_zero;
  assign track_err   = r_track_err;

  // In-flight counters, arbitration pointers and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      r_rd_ptr    <= C_RD_PTR_RST;
      r_wr_ptr    <= 1'b1;
      r_track_err <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_rd_gnt[i] && !w_ret[i])                r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_rd_gnt[i] && w_ret[i] && !w_zero[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
      if (w_rd_any) r_rd_ptr <= w_rd_idx;
      if (w_wr_any) r_wr_ptr <= w_wr_gnt[1];
      if (|w_underflow) r_track_err <= 1'b1;
    end
  end

  // Registered buffer-side request ports; address/data forced to 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_agg_read_addr_valid   <= 1'b0;
      buf_agg_read_addr         <= '0;
      buf_mm_read_addr_valid    <= 1'b0;
      buf_mm_read_addr          <= '0;
      buf_save_read_addr_valid  <= 1'b0;
      buf_save_read_addr        <= '0;
      buf_agg_write_addr_valid  <= 1'b0;
      buf_agg_write_addr        <= '0;
      buf_agg_write_data        <= '0;
      buf_load_write_addr_valid <= 1'b0;
      buf_load_write_addr       <= '0;
      buf_load_write_data       <= '0;
    end else begin
      buf_agg_read_addr_valid   <= w_rd_gnt[0];
      buf_agg_read_addr         <= w_rd_gnt[0] ? agg_rd_addr : '0;
      buf_mm_read_addr_valid    <= w_rd_gnt[1];
      buf_mm_read_addr          <= w_rd_gnt[1] ? mm_rd_addr : '0;
      buf_save_read_addr_valid  <= w_rd_gnt[2];
      buf_save_read_addr        <= w_rd_gnt[2] ? save_rd_addr : '0;
      buf_agg_write_addr_valid  <= w_wr_gnt[0];
      buf_agg_write_addr        <= w_wr_gnt[0] ? agg_wr_addr : '0;
      buf_agg_write_data        <= w_wr_gnt[0] ? agg_wr_data : '0;
      buf_load_write_addr_valid <= w_wr_gnt[1];
      buf_load_write_addr       <= w_wr_gnt[1] ? load_wr_addr : '0;
      buf_load_write_data       <= w_wr_gnt[1] ? load_wr_data : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_buffer_access_arbiter.sv
//==============================================================================
// Module      : tb_buffer_access_arbiter
// Description : Directed self-checking bench for buffer_access_arbiter.
//               Expectations for the RAW case follow BUFFER_ARB_RAW_CHECK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_buffer_access_arbiter;

  localparam int AW = 11;
  localparam int DW = 512;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          agg_rd_valid, mm_rd_valid, save_rd_valid;
  logic [AW-1:0] agg_rd_addr, mm_rd_addr, save_rd_addr;
  logic          agg_rd_ready, mm_rd_ready, save_rd_ready;
  logic          agg_wr_valid, load_wr_valid;
  logic [AW-1:0] agg_wr_addr, load_wr_addr;
  logic [DW-1:0] agg_wr_data, load_wr_data;
  logic          agg_wr_ready, load_wr_ready;
  logic          buf_agg_read_addr_valid, buf_mm_read_addr_valid, buf_save_read_addr_valid;
  logic [AW-1:0] buf_agg_read_addr, buf_mm_read_addr, buf_save_read_addr;
  logic          buf_agg_write_addr_valid, buf_load_write_addr_valid;
  logic [AW-1:0] buf_agg_write_addr, buf_load_write_addr;
  logic [DW-1:0] buf_agg_write_data, buf_load_write_data;
  logic          buf_agg_read_data_valid, buf_mm_read_data_valid, buf_save_read_data_valid;
  logic          track_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;

  buffer_access_arbiter #(
    .BUFFER_ADDR_WIDTH(AW),
    .BUFFER_DATA_WIDTH(DW),
    .MAX_OUTSTANDING  (MO)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .agg_rd_valid             (agg_rd_valid),
    .agg_rd_addr              (agg_rd_addr),
    .agg_rd_ready             (agg_rd_ready),
    .mm_rd_valid              (mm_rd_valid),
    .mm_rd_addr               (mm_rd_addr),
    .mm_rd_ready              (mm_rd_ready),
    .save_rd_valid            (save_rd_valid),
    .save_rd_addr             (save_rd_addr),
    .save_rd_ready            (save_rd_ready),
    .agg_wr_valid             (agg_wr_valid),
    .agg_wr_addr              (agg_wr_addr),
    .agg_wr_data              (agg_wr_data),
    .agg_wr_ready             (agg_wr_ready),
    .load_wr_valid            (load_wr_valid),
    .load_wr_addr             (load_wr_addr),
    .load_wr_data             (load_wr_data),
    .load_wr_ready            (load_wr_ready),
    .buf_agg_read_addr_valid  (buf_agg_read_addr_valid),
    .buf_agg_read_addr        (buf_agg_read_addr),
    .buf_mm_read_addr_valid   (buf_mm_read_addr_valid),
    .buf_mm_read_addr         (buf_mm_read_addr),
    .buf_save_read_addr_valid (buf_save_read_addr_valid),
    .buf_save_read_addr       (buf_save_read_addr),
    .buf_agg_write_addr_valid (buf_agg_write_addr_valid),
    .buf_agg_write_addr       (buf_agg_write_addr),
    .buf_agg_write_data       (buf_agg_write_data),
    .buf_load_write_addr_valid(buf_load_write_addr_valid),
    .buf_load_write_addr      (buf_load_write_addr),
    .buf_load_write_data      (buf_load_write_data),
    .buf_agg_read_data_valid  (buf_agg_read_data_valid),
    .buf_mm_read_data_valid   (buf_mm_read_data_valid),
    .buf_save_read_data_valid (buf_save_read_data_valid),
    .track_err                (track_err)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    agg_rd_valid = 0; mm_rd_valid = 0; save_rd_valid = 0;
    agg_rd_addr = '0; mm_rd_addr = '0; save_rd_addr = '0;
    agg_wr_valid = 0; load_wr_valid = 0;
    agg_wr_addr = '0; load_wr_addr = '0;
    agg_wr_data = '0; load_wr_data = '0;
    buf_agg_read_data_valid = 0; buf_mm_read_data_valid = 0; buf_save_read_data_valid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [DW-1:0] all_buf_outs();
    return DW'({buf_agg_read_addr_valid, buf_mm_read_addr_valid, buf_save_read_addr_valid,
                buf_agg_write_addr_valid, buf_load_write_addr_valid, track_err})
         | DW'(buf_agg_read_addr) | DW'(buf_mm_read_addr) | DW'(buf_save_read_addr)
         | DW'(buf_agg_write_addr) | DW'(buf_load_write_addr)
         | buf_agg_write_data | buf_load_write_data;
  endfunction

  logic [2:0] exp_rd;
  logic [1:0] exp_wr;

  initial begin
    data_a = {128{4'hA}};
    data_b = {128{4'hB}};

    // Reset state with all valids low.
    do_reset();
    check("reset_outs", all_buf_outs(), '0);
    check("reset_ready", {agg_rd_ready, mm_rd_ready, save_rd_ready, agg_wr_ready, load_wr_ready}, '0);

    // Single agg read, address 0x005.
    agg_rd_valid = 1; agg_rd_addr = 11'h005;
    #1 check("single_rd_ready", agg_rd_ready, 1);
    tick();
    agg_rd_valid = 0;
    check("single_rd_valid_t1", buf_agg_read_addr_valid, 1);
    check("single_rd_addr_t1", buf_agg_read_addr, 11'h005);
    tick();
    check("single_rd_valid_t2", buf_agg_read_addr_valid, 0);
    check("single_rd_addr_t2", buf_agg_read_addr, 0);

    // Three readers for 6 cycles: agg, mm, save, agg, mm, save.
    do_reset();
    agg_rd_valid = 1; mm_rd_valid = 1; save_rd_valid = 1;
    agg_rd_addr = 11'h100; mm_rd_addr = 11'h200; save_rd_addr = 11'h300;
    for (int k = 0; k < 6; k++) begin
      exp_rd = 3'b001 << (k % 3);
      #1 check($sformatf("rr_ready_%0d", k), {save_rd_ready, mm_rd_ready, agg_rd_ready}, exp_rd);
      tick();
      check($sformatf("rr_bufvalid_%0d", k),
            {buf_save_read_addr_valid, buf_mm_read_addr_valid, buf_agg_read_addr_valid}, exp_rd);
      check($sformatf("rr_bufaddr_%0d", k),
            buf_agg_read_addr | buf_mm_read_addr | buf_save_read_addr,
            (k % 3 == 0) ? 11'h100 : (k % 3 == 1) ? 11'h200 : 11'h300);
    end

    // Outstanding limit on mm.
    do_reset();
    mm_rd_valid = 1; mm_rd_addr = 11'h042;
    for (int k = 0; k < MO; k++) begin
      #1 check($sformatf("limit_grant_%0d", k), mm_rd_ready, 1);
      tick();
    end
    check("limit_stall_a", mm_rd_ready, 0);
    tick();
    check("limit_stall_b", mm_rd_ready, 0);
    buf_mm_read_data_valid = 1;
    #1 check("limit_ret_same_cycle", mm_rd_ready, 0);
    tick();
    buf_mm_read_data_valid = 0;
    #1 check("limit_ret_regrant", mm_rd_ready, 1);
    tick();
    check("limit_regrant_buf", buf_mm_read_addr_valid, 1);
    check("limit_stall_again", mm_rd_ready, 0);
    mm_rd_valid = 0;

    // Two writers alternate; data appears one cycle later.
    do_reset();
    agg_wr_valid = 1; agg_wr_addr = 11'h020; agg_wr_data = data_a;
    load_wr_valid = 1; load_wr_addr = 11'h030; load_wr_data = data_b;
    for (int k = 0; k < 4; k++) begin
      exp_wr = (k % 2 == 0) ? 2'b10 : 2'b01;   // {agg, load}
      #1 check($sformatf("wr_ready_%0d", k), {agg_wr_ready, load_wr_ready}, exp_wr);
      tick();
      check($sformatf("wr_bufvalid_%0d", k), {buf_agg_write_addr_valid, buf_load_write_addr_valid}, exp_wr);
      check($sformatf("wr_bufdata_%0d", k), buf_agg_write_data | buf_load_write_data,
            (k % 2 == 0) ? data_a : data_b);
      check($sformatf("wr_bufaddr_%0d", k), buf_agg_write_addr | buf_load_write_addr,
            (k % 2 == 0) ? 11'h020 : 11'h030);
    end
    agg_wr_valid = 0; load_wr_valid = 0;
    tick();
    check("wr_idle", {buf_agg_write_addr_valid, buf_load_write_addr_valid}, 0);

    // Same-cycle read/write to the same address.
    do_reset();
    load_wr_valid = 1; load_wr_addr = 11'h010; load_wr_data = data_b;
    save_rd_valid = 1; save_rd_addr = 11'h010;
    #1 check("raw_wr_ready", load_wr_ready, 1);
`ifdef BUFFER_ARB_RAW_CHECK_EN
    check("raw_rd_blocked", save_rd_ready, 0);
    tick();
    load_wr_valid = 0;
    #1 check("raw_rd_retry", save_rd_ready, 1);
    check("raw_wr_buf", buf_load_write_addr_valid, 1);
`else
    check("raw_rd_same_cycle", save_rd_ready, 1);
    tick();
    load_wr_valid = 0;
    check("raw_wr_buf", buf_load_write_addr_valid, 1);
    check("raw_rd_buf", buf_save_read_addr_valid, 1);
`endif
    tick();
    save_rd_valid = 0;

    // Underflow sets sticky track_err.
    do_reset();
    buf_save_read_data_valid = 1;
    #1 check("err_before_edge", track_err, 0);
    tick();
    buf_save_read_data_valid = 0;
    check("err_set", track_err, 1);
    tick(); tick(); tick();
    check("err_sticky", track_err, 1);

    // Asynchronous reset mid-burst.
    agg_rd_valid = 1; agg_rd_addr = 11'h077;
    mm_rd_valid = 1; mm_rd_addr = 11'h088;
    tick();
    check("burst_active", buf_agg_read_addr_valid | buf_mm_read_addr_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", all_buf_outs(), '0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    // A return for a read issued before reset is now an underflow.
    buf_agg_read_data_valid = 1;
    tick();
    buf_agg_read_data_valid = 0;
    check("err_after_reset_return", track_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/buffer_access_arbiter.md
# buffer_access_arbiter

Round-robin arbiter and read-tracking controller placed in front of one feature buffer. Arbitrates three read requesters (agg, mm, save) and two write requesters (agg, load) with valid/ready handshakes. Guarantees at most one read and one write reach the buffer per cycle, bounds in-flight reads per requester, and optionally blocks same-cycle read-after-write address conflicts.

## Interface
- BUFFER_ADDR_WIDTH, 11, buffer word address width
- BUFFER_DATA_WIDTH, 512, write data width
- MAX_OUTSTANDING, 4, max in-flight reads per read requester (1..15); counter width CW = $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- {agg,mm,save}_rd_valid  in  1 each  read request
- {agg,mm,save}_rd_addr  in  BUFFER_ADDR_WIDTH each  read address
- {agg,mm,save}_rd_ready  out  1 each  combinational grant; a transfer occurs when valid && ready
- {agg,load}_wr_valid  in  1 each  write request
- {agg,load}_wr_addr  in  BUFFER_ADDR_WIDTH each  write address
- {agg,load}_wr_data  in  BUFFER_DATA_WIDTH each  write data
- {agg,load}_wr_ready  out  1 each  combinational grant
- buf_{agg,mm,save}_read_addr_valid  out  1 each  registered, at most one high per cycle
- buf_{agg,mm,save}_read_addr  out  BUFFER_ADDR_WIDTH each  registered; 0 when the matching valid is low
- buf_{agg,load}_write_addr_valid  out  1 each  registered, at most one high per cycle
- buf_{agg,load}_write_addr / _write_data  out  BUFFER_ADDR_WIDTH / BUFFER_DATA_WIDTH  registered; 0 when idle
- buf_{agg,mm,save}_read_data_valid  in  1 each  returns from the buffer, used to retire in-flight reads
- track_err  out  1  sticky; set on counter underflow (return with count 0)

## Operation
- Read arbitration is round-robin over agg→mm→save. A pointer holds the last granted requester, and search starts at the next one. Requester i is eligible when rd_valid && cnt[i] < MAX_OUTSTANDING && !raw_block[i]. At most one rd_ready is high per cycle. The pointer updates only on a grant.
- Write arbitration is round-robin over agg/load with a 1-bit pointer. Every cycle with a valid request grants exactly one writer.
- On a read grant, the selected buf_*_read_addr_valid/addr are registered for the next cycle. On a write grant, buf_*_write_* are registered likewise. All other buf_* outputs are 0.
- In-flight counters cnt[agg/mm/save] (CW bits):
  - +1 on grant, −1 on the matching buf_*_read_data_valid.
  - Both in the same cycle: unchanged.
  - Decrement at 0: count held at 0 and track_err set.
- Grant is combinational from the current cnt. A return in the same cycle does not free a slot until the next cycle.
- Reset: all buf_* outputs 0, cnt = 0, both pointers point so that agg is first priority, track_err = 0. rd_ready/wr_ready are combinational and become 0 when all valids are 0. Reset mid-operation discards in-flight tracking; returns arriving after reset set track_err.

## Timing
- Request accepted in cycle t → buf_* address valid in cycle t+1 → buffer data valid at t+5 (buffer adds 4 cycles). Read request-to-data latency is 5 cycles.
- Write accepted at t → buf write outputs at t+1.
- Sustained throughput: 1 read + 1 write per cycle. A single requester can have MAX_OUTSTANDING reads in flight, then stalls until a return.
- A write and a read granted in the same cycle reach the buffer together. The buffer's read-first RAM would then return old data for a matching address.

## Configuration
- BUFFER_ARB_RAW_CHECK_EN defined:
  - raw_block[i] is high when rd_addr[i] equals the address of the write granted in the same cycle.
  - The read waits and is retried the next cycle; the write always wins.
  - This guarantees every accepted read observes all previously accepted writes.
- BUFFER_ARB_RAW_CHECK_EN undefined: raw_block = 0, no comparators. Same-cycle same-address read returns pre-write data.

## Test plan
- Reset, all valids low: every output 0, track_err 0. agg_rd_valid, addr 0x005 at t → buf_agg_read_addr_valid=1, addr 0x005 at t+1 only.
- All three reads valid for 6 cycles, no backpressure: grant order agg, mm, save, agg, mm, save, with exactly one buf read valid per cycle.
- MAX_OUTSTANDING=4, mm_rd_valid held, no returns: 4 grants then mm_rd_ready=0. One buf_mm_read_data_valid → exactly one more grant the following cycle.
- agg_wr and load_wr valid simultaneously for 4 cycles: writes alternate agg, load, agg, load, and write data 0xA.. / 0xB.. appear at the buffer ports one cycle later.
- With BUFFER_ARB_RAW_CHECK_EN: load_wr addr 0x010 and save_rd addr 0x010 in the same cycle → save_rd_ready=0 that cycle, granted next cycle. Without the macro: both granted in the same cycle.
- buf_save_read_data_valid pulse with cnt_save=0 → track_err=1 and stays 1 until rst_n low. Assert rst_n low mid-burst → all outputs 0 asynchronously.
